// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle RISC-V core.
// The control FSM uses the master modport; the datapath (or a bench) uses slave.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      Instruction;
    logic             Zero;
    logic             MemReady;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             RegWrite;
    logic             MemtoReg;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstRetired;

    modport master (
        input  Instruction, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg,
               Illegal, State, InstRetired
    );

    modport slave (
        output Instruction, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg,
               Illegal, State, InstRetired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on MemReady, traps on unsupported opcodes and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        EXEC_B   = 4'd9,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    state_t           state_r;
    state_t           next_s;
    logic [CNT_W-1:0] count_r;
    logic             retire_s;
    logic [6:0]       opcode_s;
    logic             unused_instr_s;

    logic       iord_s, memread_s, memwrite_s, irwrite_s, pcwrite_s, pcsrc_s;
    logic [1:0] alusrca_s, alusrcb_s, aluop_s;
    logic       regwrite_s, memtoreg_s, illegal_s;

    assign opcode_s       = bus.Instruction[6:0];
    assign unused_instr_s = ^bus.Instruction[31:7];

    // Next-state decode; only DECODE and MEM_ADDR look at the opcode.
    always_comb begin
        next_s = TRAP;
        case (state_r)
            FETCH: begin
                if (bus.MemReady) next_s = DECODE;
                else              next_s = FETCH;
            end
            DECODE: begin
                case (opcode_s)
                    OP_L:    next_s = MEM_ADDR;
                    OP_S:    next_s = MEM_ADDR;
                    OP_R:    next_s = EXEC_R;
                    OP_I:    next_s = EXEC_I;
                    OP_B:    next_s = EXEC_B;
                    default: next_s = TRAP;
                endcase
            end
            MEM_ADDR: begin
                if (opcode_s == OP_L) next_s = MEM_RD;
                else                  next_s = MEM_WR;
            end
            MEM_RD: begin
                if (bus.MemReady) next_s = MEM_WB;
                else              next_s = MEM_RD;
            end
            MEM_WB: next_s = FETCH;
            MEM_WR: begin
                if (bus.MemReady) next_s = FETCH;
                else              next_s = MEM_WR;
            end
            EXEC_R:  next_s = ALU_WB;
            EXEC_I:  next_s = ALU_WB;
            ALU_WB:  next_s = FETCH;
            EXEC_B:  next_s = FETCH;
            TRAP:    next_s = TRAP;
            default: next_s = TRAP;
        endcase
    end

    // Retire on the edge that completes an instruction; a store completes with MemReady.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            MEM_WB:  retire_s = 1'b1;
            ALU_WB:  retire_s = 1'b1;
            EXEC_B:  retire_s = 1'b1;
            MEM_WR:  retire_s = bus.MemReady;
            default: retire_s = 1'b0;
        endcase
    end

    // Datapath selects and strobes decoded from the current state.
    always_comb begin
        iord_s     = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite_s  = 1'b0;
        pcsrc_s    = 1'b0;
        alusrca_s  = 2'b00;
        alusrcb_s  = 2'b00;
        aluop_s    = 2'b00;
        regwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            FETCH: begin
                memread_s = 1'b1;
                alusrcb_s = 2'b01;
                // Gate with reset so a held-high MemReady cannot load IR/PC during reset.
                irwrite_s = bus.MemReady & ~reset;
                pcwrite_s = bus.MemReady & ~reset;
            end
            DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
            end
            MEM_ADDR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b10;
            end
            MEM_RD: begin
                memread_s = 1'b1;
                iord_s    = 1'b1;
            end
            MEM_WB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            MEM_WR: begin
                memwrite_s = 1'b1;
                iord_s     = 1'b1;
            end
            EXEC_R: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b10;
            end
            EXEC_I: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b10;
                aluop_s   = 2'b10;
            end
            ALU_WB: regwrite_s = 1'b1;
            EXEC_B: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b01;
                pcsrc_s   = 1'b1;
                pcwrite_s = bus.Zero;
            end
            TRAP:    illegal_s = 1'b1;
            default: illegal_s = 1'b1;
        endcase
    end

    // State register and wrapping retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            count_r <= '0;
        end else begin
            state_r <= next_s;
            if (retire_s) count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.IorD        = iord_s;
    assign bus.MemRead     = memread_s;
    assign bus.MemWrite    = memwrite_s;
    assign bus.IRWrite     = irwrite_s;
    assign bus.PCWrite     = pcwrite_s;
    assign bus.PCSrc       = pcsrc_s;
    assign bus.ALUSrcA     = alusrca_s;
    assign bus.ALUSrcB     = alusrcb_s;
    assign bus.ALUOp       = aluop_s;
    assign bus.RegWrite    = regwrite_s;
    assign bus.MemtoReg    = memtoreg_s;
    assign bus.Illegal     = illegal_s;
    assign bus.State       = state_r;
    assign bus.InstRetired = count_r;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (CNT_W=4 build so the counter wrap is reachable).
module tb_multicycle_control;
    localparam int CW = 4;

    typedef struct packed {
        logic [15:0]   id;
        logic [3:0]    st;
        logic [14:0]   ctrl;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;
    logic [CW-1:0] exp_cnt;
    logic [15:0]   step_id;
    logic          drive_done;

    multicycle_control_if #(.CNT_W(CW)) bus ();
    multicycle_control #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control word {IorD,MemRead,MemWrite,IRWrite,PCWrite,PCSrc,A[2],B[2],Op[2],RegWrite,MemtoReg,Illegal}
    function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z, input logic rst);
        logic iord, mrd, mwr, irw, pcw, pcs, rw, m2r, ill;
        logic [1:0] a, b, op;
        iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; pcw = 1'b0; pcs = 1'b0;
        rw = 1'b0; m2r = 1'b0; ill = 1'b0; a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; b = 2'b01; irw = mr & ~rst; pcw = mr & ~rst; end
            4'd1:  begin a = 2'b01; b = 2'b10; end
            4'd2:  begin a = 2'b10; b = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin a = 2'b10; op = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b10; op = 2'b10; end
            4'd8:  begin rw = 1'b1; end
            4'd9:  begin a = 2'b10; op = 2'b01; pcs = 1'b1; pcw = z; end
            4'd15: begin ill = 1'b1; end
            default: begin ill = 1'b1; end
        endcase
        return {iord, mrd, mwr, irw, pcw, pcs, a, b, op, rw, m2r, ill};
    endfunction

    // One cycle of stimulus: drive inputs after the edge, queue the expected response.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic rst, input logic ret);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.MemReady = mr;
        bus.Zero     = z;
        if (rst) exp_cnt = '0;
        e.id   = step_id;
        e.st   = st;
        e.ctrl = exp_ctrl(st, mr, z, rst);
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        step_id = step_id + 16'd1;
        if (ret) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic run_addi();
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCSrc,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.MemtoReg, bus.Illegal};
                n_checks = n_checks + 1;
                if (bus.State === e.st && act === e.ctrl && bus.InstRetired === e.cnt) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL step%0d: got state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
                             e.id, bus.State, act, bus.InstRetired, e.st, e.ctrl, e.cnt);
                end
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        exp_cnt         = '0;
        step_id         = 16'd0;
        drive_done      = 1'b0;
        reset           = 1'b1;
        bus.MemReady    = 1'b0;
        bus.Zero        = 1'b0;
        bus.Instruction = 32'h0000_0013;

        // Reset held with MemReady high: IRWrite/PCWrite must stay gated.
        cyc(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // ADD: 0,1,6,8
        bus.Instruction = 32'h0020_81B3;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd8, 1'b1, 1'b0, 1'b0, 1'b1);

        // LW with 2 FETCH stalls and 3 MEM_RD stalls: 10 cycles
        bus.Instruction = 32'h0000_A103;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0, 1'b0, 1'b1);

        // BEQ taken then not taken
        bus.Instruction = 32'h0020_8463;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd9, 1'b1, 1'b0, 1'b0, 1'b1);

        // ADDI
        bus.Instruction = 32'h0010_8093;
        run_addi();

        // SW with one write stall, retiring on the MemReady edge
        bus.Instruction = 32'h0020_A023;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd5, 1'b1, 1'b0, 1'b0, 1'b1);

        // Unsupported opcode: trap, counter frozen for 20 cycles
        bus.Instruction = 32'h0000_007F;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(4'd15, i[0], i[1], 1'b0, 1'b0);

        // Reset out of TRAP
        cyc(4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset asserted mid-MEM_RD while the read is stalled
        bus.Instruction = 32'h0000_A103;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 16 ADDIs from zero: counter reaches 15 then wraps to 0
        bus.Instruction = 32'h0010_8093;
        for (int i = 0; i < 16; i++) run_addi();
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        drive_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (drive_done === 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
